// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges the execute stage to a word-only data memory. Loads of a byte,
// halfword or word are read and then sign- or zero-extended. Sub-word stores
// are done as read-modify-write, because the memory has only one write enable
// per word. The unit accepts a single request and owns the memory port until
// that request is answered.
//
// Configuration:
//   LSU_ACCESS_FAULT_EN (macro) - when defined, an access at or beyond word
//                                 MEM_WORDS completes with resp_error and never
//                                 reaches the memory.
//   MEM_WORDS (parameter)       - number of 32-bit words behind the port.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready valid/ready handshake from the core (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 halfword, 10 word, 11 reserved
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr            byte address
//   req_wdata           store data, right-justified
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_error          misaligned, reserved size or access fault
//   mem_address         word-aligned memory address
//   mem_write_data      merged word to write
//   mem_write_enable    write strobe, only in WRITE
//   mem_read_data       combinational read data for mem_address
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  // Latched request; the live request inputs are only looked at in IDLE.
  logic        write_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        error_reg;
  logic [31:0] word_reg;

  logic        accept;
  logic        req_error;
  logic [31:0] merged_word;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  assign accept = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Request checking (on the live inputs, at the accept edge)
  // ---------------------------------------------------------------------------
`ifdef LSU_ACCESS_FAULT_EN
  localparam logic [31:0] MEM_WORDS_LIMIT = 32'(MEM_WORDS);
`else
  // Without the range check the memory size is irrelevant here; it is only
  // referenced to flag a nonsensical configuration.
  if (MEM_WORDS < 1) begin : g_mem_words_invalid
  end
`endif

  always_comb begin
    req_error = 1'b0;
    case (req_size)
      2'b01:   req_error = req_addr[0];
      2'b10:   req_error = |req_addr[1:0];
      2'b11:   req_error = 1'b1;
      default: req_error = 1'b0;
    endcase
`ifdef LSU_ACCESS_FAULT_EN
    // Misaligned requests are already errors, so OR-ing the range check in
    // covers exactly the aligned out-of-range accesses.
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS_LIMIT) begin
      req_error = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State and request registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      write_reg    <= 1'b0;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      error_reg    <= 1'b0;
      word_reg     <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        write_reg    <= req_write;
        size_reg     <= req_size;
        unsigned_reg <= req_unsigned;
        addr_reg     <= req_addr;
        wdata_reg    <= req_wdata;
        error_reg    <= req_error;
      end
      if (state_reg == READ) begin
        word_reg <= mem_read_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_error) begin
            state_next = RESP;
          end else if (req_write && (req_size == 2'b10)) begin
            state_next = WRITE;  // full word needs no merge
          end else begin
            state_next = READ;
          end
        end
      end
      READ:    state_next = write_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: store merge and load extraction from the captured word
  // ---------------------------------------------------------------------------
  always_comb begin
    merged_word = word_reg;
    case (size_reg)
      2'b00:   merged_word[{addr_reg[1:0], 3'b000} +: 8] = wdata_reg[7:0];
      2'b01:   merged_word[{addr_reg[1], 4'b0000} +: 16] = wdata_reg[15:0];
      default: merged_word = wdata_reg;
    endcase
  end

  assign lane_byte = word_reg[{addr_reg[1:0], 3'b000} +: 8];
  assign lane_half = word_reg[{addr_reg[1], 4'b0000} +: 16];

  always_comb begin
    load_data = word_reg;
    case (size_reg)
      2'b00:   load_data = unsigned_reg ? {24'd0, lane_byte}
                                        : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_data = unsigned_reg ? {16'd0, lane_half}
                                        : {{16{lane_half[15]}}, lane_half};
      default: load_data = word_reg;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Reset is folded into the strobes so that a write or response
  // pending in the reset cycle is dropped in that same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready        = (state_reg == IDLE);
    resp_valid       = (state_reg == RESP) && !reset;
    resp_error       = resp_valid && error_reg;
    resp_rdata       = (resp_valid && !error_reg && !write_reg) ? load_data : 32'd0;
    mem_address      = {addr_reg[31:2], 2'b00};
    mem_write_enable = (state_reg == WRITE) && !reset;
    mem_write_data   = (state_reg == WRITE) ? merged_word : 32'd0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory model: combinational read, write on the rising edge.
  logic [31:0] mem [0:255];
  int          wr_count;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;

  assign mem_read_data = mem[mem_address[9:2]];

  initial begin
    wr_count     = 0;
    last_wr_addr = 32'd0;
    last_wr_data = 32'd0;
  end

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_address[9:2]] <= mem_write_data;
      wr_count              <= wr_count + 1;
      last_wr_addr          <= mem_address;
      last_wr_data          <= mem_write_data;
    end
  end

  // Scoreboard entry: request plus the response it must produce.
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          writes;
  } txn_t;

  txn_t exp_q[$];

  int          checks;
  int          fails;
  logic        obs_err;
  logic [31:0] obs_rdata;
  int          obs_lat;
  int          obs_writes;

  // Drive one request, push its expectation, wait (bounded) for resp_valid.
  task automatic send(input txn_t t);
    int w0;
    exp_q.push_back(t);
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = t.wr;
    req_size     = t.size;
    req_unsigned = t.uns;
    req_addr     = t.addr;
    req_wdata    = t.wdata;
    w0           = wr_count;
    @(posedge clk);
    obs_lat = 1;
    #1;
    // Scramble the inputs: the unit must work from its latched copy.
    req_valid    = 1'b0;
    req_write    = ~t.wr;
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = ~t.uns;
    req_addr     = $urandom;
    req_wdata    = $urandom;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) break;
      @(posedge clk);
      obs_lat++;
    end
    if (!resp_valid) begin
      checks++;
      fails++;
      $display("FAIL response_timeout addr=%08h got no resp_valid required resp_valid=1", t.addr);
    end
    obs_err    = resp_error;
    obs_rdata  = resp_rdata;
    obs_writes = wr_count - w0;
    $display("txn wr=%0b size=%0d addr=%08h wdata=%08h -> err=%0b rdata=%08h lat=%0d writes=%0d",
             t.wr, t.size, t.addr, t.wdata, obs_err, obs_rdata, obs_lat, obs_writes);
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 2'b00;
    req_unsigned = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_error, mem_write_enable} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags got ready/valid/err/we=%04b required 1000",
               {req_ready, resp_valid, resp_error, mem_write_enable});
    end
    checks++;
    if ({resp_rdata, mem_address, mem_write_data} !== 96'd0) begin
      fails++;
      $display("FAIL reset_data got rdata=%08h addr=%08h wdata=%08h required all zero",
               resp_rdata, mem_address, mem_write_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_word_round_trip;
    txn_t tbl[3];
    txn_t t;
    tbl[0] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1};
    tbl[1] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,       1'b0, 32'hDEADBEEF, 2, 0};
    tbl[2] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0, 2, 1};
    for (int i = 0; i < 3; i++) begin
      send(tbl[i]);
      t = exp_q.pop_front();
      checks++;
      if (obs_err !== t.err || obs_rdata !== t.rdata) begin
        fails++;
        $display("FAIL word_trip[%0d] got err=%0b rdata=%08h required err=%0b rdata=%08h",
                 i, obs_err, obs_rdata, t.err, t.rdata);
      end
      checks++;
      if (obs_lat != t.lat || obs_writes != t.writes) begin
        fails++;
        $display("FAIL word_trip_timing[%0d] got lat=%0d writes=%0d required lat=%0d writes=%0d",
                 i, obs_lat, obs_writes, t.lat, t.writes);
      end
    end
  endtask

  task automatic test_byte_rmw;
    txn_t t;
    send('{1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAA, 1'b0, 32'h0, 3, 1});
    t = exp_q.pop_front();
    checks++;
    if (obs_err !== t.err || obs_rdata !== t.rdata || obs_lat != t.lat || obs_writes != t.writes) begin
      fails++;
      $display("FAIL byte_rmw got err=%0b rdata=%08h lat=%0d writes=%0d required err=%0b rdata=%08h lat=%0d writes=%0d",
               obs_err, obs_rdata, obs_lat, obs_writes, t.err, t.rdata, t.lat, t.writes);
    end
    checks++;
    if (last_wr_data !== 32'h11AA3344 || last_wr_addr !== 32'h10) begin
      fails++;
      $display("FAIL byte_rmw_merge got data=%08h addr=%08h required data=11aa3344 addr=00000010",
               last_wr_data, last_wr_addr);
    end
  endtask

  task automatic test_extension;
    txn_t tbl[7];
    txn_t t;
    // Memory word 0x10 holds 0x11AA3344 here.
    tbl[0] = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFFFFAA, 2, 0};
    tbl[1] = '{1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, 32'h000000AA, 2, 0};
    tbl[2] = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h00003344, 2, 0};
    tbl[3] = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h00000011, 2, 0};
    // Halfword store to the upper lane, then read it back both ways.
    tbl[4] = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 1'b0, 32'h0, 3, 1};
    tbl[5] = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFFBEEF, 2, 0};
    tbl[6] = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0000BEEF, 2, 0};
    for (int i = 0; i < 7; i++) begin
      send(tbl[i]);
      t = exp_q.pop_front();
      checks++;
      if (obs_err !== t.err || obs_rdata !== t.rdata || obs_lat != t.lat || obs_writes != t.writes) begin
        fails++;
        $display("FAIL extension[%0d] got err=%0b rdata=%08h lat=%0d writes=%0d required err=%0b rdata=%08h lat=%0d writes=%0d",
                 i, obs_err, obs_rdata, obs_lat, obs_writes, t.err, t.rdata, t.lat, t.writes);
      end
    end
    checks++;
    if (mem[4] !== 32'hBEEF3344) begin
      fails++;
      $display("FAIL half_store_mem got %08h required beef3344", mem[4]);
    end
  endtask

  task automatic test_misaligned;
    txn_t tbl[4];
    txn_t t;
    logic [31:0] m4;
    logic [31:0] m8;
    m4 = mem[4];
    m8 = mem[8];
    tbl[0] = '{1'b1, 2'b01, 1'b0, 32'h11, 32'h0000CAFE, 1'b1, 32'h0, 1, 0};
    tbl[1] = '{1'b0, 2'b10, 1'b0, 32'h22, 32'h0,        1'b1, 32'h0, 1, 0};
    tbl[2] = '{1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, 1'b1, 32'h0, 1, 0};
    tbl[3] = '{1'b1, 2'b10, 1'b0, 32'h13, 32'h66666666, 1'b1, 32'h0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      send(tbl[i]);
      t = exp_q.pop_front();
      checks++;
      if (obs_err !== t.err || obs_rdata !== t.rdata || obs_lat != t.lat || obs_writes != t.writes) begin
        fails++;
        $display("FAIL misaligned[%0d] got err=%0b rdata=%08h lat=%0d writes=%0d required err=%0b rdata=%08h lat=%0d writes=%0d",
                 i, obs_err, obs_rdata, obs_lat, obs_writes, t.err, t.rdata, t.lat, t.writes);
      end
    end
    checks++;
    if (mem[4] !== m4 || mem[8] !== m8) begin
      fails++;
      $display("FAIL misaligned_mem got %08h/%08h required %08h/%08h", mem[4], mem[8], m4, m8);
    end
  endtask

  task automatic test_back_to_back;
    // req_valid stays high: the second load may only be accepted in IDLE.
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h10;
    @(negedge clk);  // READ
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_read got ready=%0b valid=%0b required 0/0", req_ready, resp_valid);
    end
    @(negedge clk);  // RESP
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'hBEEF3344) begin
      fails++;
      $display("FAIL b2b_resp got ready=%0b valid=%0b rdata=%08h required 0/1/beef3344",
               req_ready, resp_valid, resp_rdata);
    end
    @(negedge clk);  // IDLE again, accepts at next edge
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle got ready=%0b valid=%0b required 1/0", req_ready, resp_valid);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hBEEF3344) begin
      fails++;
      $display("FAIL b2b_second got valid=%0b rdata=%08h required 1/beef3344", resp_valid, resp_rdata);
    end
    @(negedge clk);
    $display("txn back_to_back loads of 0x10 done");
  endtask

  task automatic test_reset_mid_op;
    int          w0;
    int          seen;
    logic [31:0] m5;
    logic [31:0] m6;
    w0   = wr_count;
    m5   = mem[5];
    m6   = mem[6];
    seen = 0;
    // Byte store, reset during READ.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h14;
    req_wdata = 32'h00000055;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_read_recover got ready=%0b valid=%0b required 1/0", req_ready, resp_valid);
    end
    // Word store, reset during WRITE: the strobe must drop in that cycle.
    req_valid = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h18;
    req_wdata = 32'h77777777;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_write_enable !== 1'b0 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_write_strobe got we=%0b valid=%0b required 0/0", mem_write_enable, resp_valid);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++;
    if (seen != 0 || wr_count != w0 || mem[5] !== m5 || mem[6] !== m6 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_op got resp=%0d writes=%0d ready=%0b required resp=0 writes=0 ready=1",
               seen, wr_count - w0, req_ready);
    end
    $display("txn reset_mid_op byte store at 0x14 and word store at 0x18 abandoned");
  endtask

  task automatic test_fault;
    txn_t t;
`ifdef LSU_ACCESS_FAULT_EN
    send('{1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, 1'b1, 32'h0, 1, 0});
`else
    send('{1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, 1'b0, 32'h0, 2, 1});
`endif
    t = exp_q.pop_front();
    checks++;
    if (obs_err !== t.err || obs_rdata !== t.rdata || obs_lat != t.lat || obs_writes != t.writes) begin
      fails++;
      $display("FAIL fault got err=%0b rdata=%08h lat=%0d writes=%0d required err=%0b rdata=%08h lat=%0d writes=%0d",
               obs_err, obs_rdata, obs_lat, obs_writes, t.err, t.rdata, t.lat, t.writes);
    end
`ifndef LSU_ACCESS_FAULT_EN
    checks++;
    if (last_wr_addr !== 32'h100 || last_wr_data !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL fault_passthru got addr=%08h data=%08h required 00000100/cafef00d",
               last_wr_addr, last_wr_data);
    end
`endif
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_word_round_trip();
    test_byte_rmw();
    test_extension();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_op();
    test_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the word-only data memory.
- The data memory has a single word write enable, so sub-word stores are done here as read-modify-write.
- Also handles byte/halfword loads with sign or zero extension, alignment checking, and a valid/ready handshake to the core.
- One request is in flight at a time; the block owns the memory port for the whole transaction.

Parameters:
- MEM_WORDS, 64: number of 32-bit words behind the memory port; used only by the optional fault check.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- req_valid, input, 1: core presents a request.
- req_ready, output, 1: unit can accept; high only in IDLE.
- req_write, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned, input, 1: loads only; 1 = zero-extend, 0 = sign-extend.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data; byte in [7:0], halfword in [15:0].
- resp_valid, output, 1: one-cycle pulse, transaction complete.
- resp_rdata, output, 32: extended load data; 0 for stores and errors.
- resp_error, output, 1: qualified by resp_valid; misaligned, reserved size or fault.
- mem_address, output, 32: word-aligned address {addr[31:2],2'b00}.
- mem_write_data, output, 32: merged word.
- mem_write_enable, output, 1: memory write strobe.
- mem_read_data, input, 32: combinational read data for mem_address.

Behaviour:
- Reset values:
  - State IDLE; req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - mem_write_enable=0, mem_address=0, mem_write_data=0.
  - All request registers cleared.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - A handshake is req_valid && req_ready.
  - On a handshake, latch write, size, unsigned, addr and wdata.
  - Next state:
    - error condition -> RESP with resp_error=1
    - word store -> WRITE
    - otherwise (load or sub-word store) -> READ
- Error conditions:
  - size 11
  - halfword with addr[0]=1
  - word with addr[1:0]!=00
- READ:
  - Drive mem_address from the latched address.
  - Capture mem_read_data into a word register.
  - Load -> RESP. Store -> WRITE.
- WRITE:
  - mem_write_enable=1 for exactly this cycle.
  - Byte store: mem_write_data is the captured word with lane addr[1:0] replaced by wdata[7:0].
  - Halfword store: lane addr[1] (0 = [15:0], 1 = [31:16]) replaced by wdata[15:0].
  - Word store: mem_write_data = wdata.
  - Next state RESP.
- RESP:
  - resp_valid=1 for one cycle.
  - Load: resp_rdata = selected lane, extended to 32 bits per req_unsigned.
  - Next state IDLE; req_ready returns to 1 the following cycle.
- Latency from the accept edge to the resp_valid cycle:
  - word store 2 cycles
  - load 2 cycles
  - sub-word store 3 cycles
  - error 1 cycle
- mem_write_enable is never high outside WRITE. Errored requests never touch memory.
- req_valid held high during RESP is not accepted until IDLE (no back-to-back accept in the same cycle).
- Reset asserted in any state returns to IDLE next edge:
  - a pending WRITE is abandoned and no write occurs in that cycle
  - resp_valid is not produced
- Inputs are ignored outside IDLE; request fields are used only from the latched copies.

Optional Feature:
- Macro: LSU_ACCESS_FAULT_EN.
- When defined: an aligned request with addr[31:2] >= MEM_WORDS is an error. It takes the error path (no memory access, resp_error=1, resp_rdata=0).
- When undefined: no range check; upper address bits pass through and the memory indexing handles them.

Test Plan:
- Word round trip: store 0xDEADBEEF to addr 0x10, then load word 0x10 -> one write strobe, resp_rdata=0xDEADBEEF, store latency 2, load latency 2.
- Byte RMW: memory word 0x10 = 0x11223344; store byte 0xAA to 0x12 -> exactly one READ then one WRITE with mem_write_data=0x11AA3344.
- Extension, with word 0x10 = 0x11AA3344:
  - signed byte load 0x12 -> 0xFFFFFFAA; unsigned -> 0x000000AA
  - signed halfword load 0x10 -> 0x00003344
- Misalignment: halfword store at 0x11, then word load at 0x22 -> each gives resp_error=1 one cycle after accept, no mem_write_enable, memory unchanged.
- Reset mid-op: byte store accepted, reset asserted in the READ cycle -> no write strobe, no resp_valid, req_ready=1 the cycle after reset deasserts.
- With LSU_ACCESS_FAULT_EN and MEM_WORDS=64: word store to 0x100 -> resp_error=1, no write. Without the macro -> write issued to mem_address 0x100.
